// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state codes and control constants for the divider
package div_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIVSTART  = 1'b1;
  localparam logic DIVSTOP   = 1'b0;
  localparam logic RSTENABLE = 1'b1;

endpackage

// File: rtl/div.sv
// rtl/div.sv - multi-cycle restoring divider returning {remainder, quotient}
module div
  import div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    return ~v + DATA_W'(1);
  endfunction

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic is_signed);
    return (is_signed && v[DATA_W-1]) ? negate(v) : v;
  endfunction

  div_state_e          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*DATA_W:0]   work_q;
  logic [2*DATA_W:0]   work_d;
  logic [DATA_W-1:0]   divisor_q;
  logic                signed_q;
  logic                sign1_q;
  logic                sign2_q;

  // work_q = {rem, quo, 1'b0}: the window [2*DATA_W:DATA_W] is the remainder
  // already shifted left with the next dividend bit, 33 bits wide so a
  // divisor with its top bit set is still compared correctly.
  logic [DATA_W:0]     rem_sh;
  logic [DATA_W-1:0]   sub;
  logic                fits;
  logic [DATA_W-1:0]   quo_raw, rem_raw, quo_fix, rem_fix;

  always_comb begin
    rem_sh  = work_q[2*DATA_W:DATA_W];
    fits    = rem_sh >= {1'b0, divisor_q};
    sub     = rem_sh[DATA_W-1:0] - divisor_q;
    work_d  = fits ? {sub, work_q[DATA_W-1:0], 1'b1}
                   : {work_q[2*DATA_W-1:0], 1'b0};
    quo_raw = work_d[DATA_W-1:0];
    rem_raw = work_d[2*DATA_W:DATA_W+1];
    quo_fix = (signed_q && (sign1_q ^ sign2_q)) ? negate(quo_raw) : quo_raw;
    rem_fix = (signed_q && sign1_q) ? negate(rem_raw) : rem_raw;
  end

  always_ff @(posedge clk) begin
    if (rst == RSTENABLE) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      signed_q  <= 1'b0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      result_o  <= '0;
      ready_o   <= 1'b0;
    end else begin
      case (state_q)
        DIV_FREE: begin
          if (start_i == DIVSTART && !annul_i) begin
            signed_q <= signed_div_i;
            sign1_q  <= opdata1_i[DATA_W-1];
            sign2_q  <= opdata2_i[DATA_W-1];
            if (opdata2_i == '0) begin
              state_q <= DIV_BY_ZERO;
            end else begin
              state_q   <= DIV_ON;
              cnt_q     <= '0;
              work_q    <= {{DATA_W{1'b0}}, magnitude(opdata1_i, signed_div_i), 1'b0};
              divisor_q <= magnitude(opdata2_i, signed_div_i);
            end
          end
        end
        DIV_BY_ZERO: begin
          state_q  <= DIV_END;
          result_o <= '0;
          ready_o  <= 1'b1;
        end
        DIV_ON: begin
          if (annul_i) begin
            state_q  <= DIV_FREE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end else begin
            work_q <= work_d;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
              state_q  <= DIV_END;
              result_o <= {rem_fix, quo_fix};
              ready_o  <= 1'b1;
            end
          end
        end
        DIV_END: begin
          if (start_i == DIVSTOP) begin
            state_q  <= DIV_FREE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// tb/tb_div.sv - scoreboard bench for the restoring divider
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  div #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    if (b == 32'h0) return 64'h0;
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      sa = a;
      sb = b;
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {a % b, a / b};
  endfunction

  // Drives one request, scrambles operands after E0, checks latency, result, hold and release.
  task automatic do_div(input string tag, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int cycles;
    logic [63:0] want;
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    exp_q.push_back(exp);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      opdata1_i = $urandom;
      opdata2_i = $urandom;
      signed_div_i = $urandom_range(0, 1);
    end while (!ready_o && cycles < 100);
    check({tag, "_lat"}, 64'(cycles), 64'(exp_lat));
    want = exp_q.pop_front();
    check({tag, "_res"}, result_o, want);
    @(negedge clk);
    check({tag, "_hold"}, {63'h0, ready_o}, 64'h1);
    check({tag, "_holdres"}, result_o, want);
    start_i = 1'b0;
    @(negedge clk);
    check({tag, "_drop"}, {63'h0, ready_o}, 64'h0);
    check({tag, "_dropres"}, result_o, 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    logic seen;
    logic [31:0] ra, rb;
    logic rs;

    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'h0; opdata2_i = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_ready", {63'h0, ready_o}, 64'h0);
    check("rst_result", result_o, 64'h0);
    rst = 1'b0;

    do_div("u100_7",   1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    do_div("s_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    do_div("s_7_m2",   1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);
    do_div("u_div0",   1'b0, 32'd55, 32'd0, 64'h0, 2);
    do_div("s_div0",   1'b1, 32'hFFFF_0000, 32'd0, 64'h0, 2);
    do_div("s_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
    do_div("u_max_1",  1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 33);
    do_div("u_bigdiv", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, {32'h7FFF_FFFE, 32'h1}, 33);

    // Flush ten cycles into a divide: no result may appear.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (10) @(negedge clk);
    annul_i = 1'b1; start_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      annul_i = 1'b0;
      if (ready_o) seen = 1'b1;
    end
    check("annul_noready", {63'h0, seen}, 64'h0);
    do_div("after_annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

    // annul_i in FREE blocks a held start.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd8; opdata2_i = 32'd2; start_i = 1'b1; annul_i = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) seen = 1'b1;
    end
    check("annul_free", {63'h0, seen}, 64'h0);
    start_i = 1'b0; annul_i = 1'b0;
    do_div("after_free", 1'b1, 32'hFFFF_FFF8, 32'd2, {32'd0, 32'hFFFF_FFFC}, 33);

    // start dropped mid-divide: the divide finishes and ready pulses once.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1;
    exp_q.push_back({32'd0, 32'd10});
    cycles = 0;
    repeat (5) begin @(negedge clk); cycles++; end
    start_i = 1'b0;
    while (!ready_o && cycles < 100) begin @(negedge clk); cycles++; end
    check("drop_lat", 64'(cycles), 64'd33);
    check("drop_res", result_o, exp_q.pop_front());
    @(negedge clk);
    check("drop_pulse", {63'h0, ready_o}, 64'h0);

    // Reset at cycle 20 mid-divide.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", {63'h0, ready_o}, 64'h0);
    check("rst_mid_result", result_o, 64'h0);
    rst = 1'b0;
    do_div("after_rst", 1'b0, 32'd1000, 32'd7, {32'd6, 32'd142}, 33);

    // Reset while a result is held in DIV_END.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd21; opdata2_i = 32'd4; start_i = 1'b1;
    cycles = 0;
    do begin @(negedge clk); cycles++; end while (!ready_o && cycles < 100);
    check("end_res", result_o, {32'd1, 32'd5});
    rst = 1'b1;
    @(negedge clk);
    check("rst_end_ready", {63'h0, ready_o}, 64'h0);
    check("rst_end_result", result_o, 64'h0);
    rst = 1'b0; start_i = 1'b0;

    for (int i = 0; i < 8; i++) begin
      rs = $urandom_range(0, 1);
      ra = $urandom;
      rb = (i < 4) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (rb == 32'h0) rb = 32'd3;
      do_div($sformatf("rand%0d", i), rs, ra, rb, model(rs, ra, rb), 33);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
